shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Multi-cycle sequencer that applies a single-position, zero-fill left-shift step repeatedly to produce a left shift by a requested amount.
- Accepts a start request with an operand and a shift amount, then steps the shift once per clock.
- Reports completion with a one-cycle done pulse and holds the result.
- Sits between control logic and the one-bit shift datapath. The shift amount is turned into a sequence of step-enable cycles instead of building a barrel shifter.

Parameters:
- WIDTH, 4, operand/result width in bits.
- AMT_W, 3, shift-amount port width; must satisfy 2^AMT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- din  input  WIDTH  operand; captured on an accepted start.
- amt  input  AMT_W  shift amount; captured on an accepted start.
- busy  output  1  high in the SHIFT and DONE states.
- step  output  1  shift-step select; high exactly in the cycles where the working register shifts.
- done  output  1  one-cycle completion pulse.
- dout  output  WIDTH  result; valid when done=1; held until the next accepted start.

Behaviour:
- Reset (rst=1 at a clock edge), from any state including mid-operation:
  - state returns to IDLE.
  - working register and count clear to 0.
  - dout=0, busy=0, done=0, step=0.
  - Any in-flight operation is discarded.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - busy=0, step=0, done=0.
  - If start=1 at an edge: load wreg<=din and cnt<=min(amt, WIDTH).
  - Next state is SHIFT if the clamped amount is non-zero, otherwise DONE.
- SHIFT:
  - busy=1, step=1.
  - Each edge: wreg<={wreg[WIDTH-2:0],1'b0} and cnt<=cnt-1.
  - When cnt==1 at the edge, go to DONE.
- DONE:
  - busy=1, done=1 for exactly one cycle. dout shows the final wreg during this cycle.
  - Next edge: go to IDLE.
- dout is registered. It updates only when DONE is entered, and is stable from the done cycle until the next accepted start.
- Latency: done is high during cycle N+1 after the start edge, where N = min(amt, WIDTH).
- Clamping: any amt >= WIDTH takes WIDTH shift cycles and gives an all-zero result (WIDTH with no rotate).
- amt=0: no SHIFT cycles, step never asserts, DONE follows immediately, dout=din.
- start while busy=1 (SHIFT or DONE): ignored, with no effect on state, operands or outputs.
- start=1 in the same cycle done=1: ignored. A new request is accepted only once the block is back in IDLE.
- start held high: one operation per IDLE visit. Back-to-back operations are separated by one IDLE cycle.
- rst and start asserted together: rst wins.
- Zero-fill at the LSB on every step. Bits shifted out of the MSB are discarded.

Optional Feature:
- Macro: SHIFT_SEQ_ROTATE_EN.
- With the macro defined:
  - An extra input port rot (1 bit) is added and captured on an accepted start.
  - When the captured rot=1, each step feeds the old MSB into the LSB (rotate left) instead of 0.
  - When rot=1, the amount clamp uses amt mod WIDTH instead of min(amt, WIDTH). A result of 0 takes the amt=0 path.
- Without the macro: the rot port is absent and behaviour is exactly the zero-fill shift above.

Test Plan (WIDTH=4):
- din=4'b1011, amt=1, start pulse -> step high 1 cycle; done in cycle 2 after start; dout=4'b0110.
- din=4'b0011, amt=3 -> busy=1 and step=1 for cycles 1-3; done in cycle 4; dout=4'b1000, held until the next start.
- din=4'b1010, amt=0 -> step never high; done in cycle 1; dout=4'b1010.
- din=4'b1111, amt=7 -> clamped to 4 steps; done in cycle 5; dout=4'b0000.
- din=4'b0001, amt=3; start re-pulsed with din=4'b1111 in cycle 2 (ignored); then rst in cycle 2 of a second 3-step operation:
  - first operation gives dout=4'b1000.
  - after rst, in the next cycle: busy=0, done=0, dout=4'b0000, state IDLE.
- With SHIFT_SEQ_ROTATE_EN defined:
  - din=4'b1001, amt=1, rot=1 -> dout=4'b0011.
  - din=4'b1001, amt=5, rot=1 -> 1 step; dout=4'b0011.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Left-shift sequencer: turns a shift amount into one single-bit shift step per clock.
// Optional rotate-left mode is compiled in with SHIFT_SEQ_ROTATE_EN.
module shift_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amt,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic             rot,
`endif
    output logic             busy,
    output logic             step,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       state_dbg
);

    // Handshake: start is taken only at an edge where the block is in IDLE; done is a
    // one-cycle pulse with dout valid, and dout then holds until the next accepted start.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] WIDTH_A = AMT_W'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] wreg;
    logic [AMT_W-1:0] cnt;
    logic [AMT_W-1:0] load_amt;
    logic [WIDTH-1:0] shifted;
    logic             fill;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic             rot_q;
`endif

    always_comb begin
        fill     = 1'b0;
        load_amt = (amt >= WIDTH_A) ? WIDTH_A : amt;
`ifdef SHIFT_SEQ_ROTATE_EN
        if (rot_q) fill = wreg[WIDTH-1];
        if (rot) load_amt = amt % WIDTH_A;
`endif
        shifted = {wreg[WIDTH-2:0], fill};
    end

    assign state_dbg = state;

    // Outputs are registered alongside the state so they change exactly with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wreg  <= '0;
            cnt   <= '0;
            dout  <= '0;
            busy  <= 1'b0;
            step  <= 1'b0;
            done  <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        wreg <= din;
                        cnt  <= load_amt;
                        busy <= 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
                        rot_q <= rot;
`endif
                        if (load_amt != '0) begin
                            state <= SHIFT;
                            step  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            dout  <= din;
                        end
                    end
                end
                SHIFT: begin
                    wreg <= shifted;
                    cnt  <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state <= DONE;
                        step  <= 1'b0;
                        done  <= 1'b1;
                        dout  <= shifted;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    step  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed vectors feed an expected queue, a monitor checks each done.
// Rotate vectors are included when SHIFT_SEQ_ROTATE_EN is defined.
module tb_shift_seq_ctrl;
    localparam int WIDTH = 4;
    localparam int AMT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] din;
    logic [AMT_W-1:0] amt;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic             rot;
`endif
    logic             busy;
    logic             step;
    logic             done;
    logic [WIDTH-1:0] dout;
    logic [1:0]       state_dbg;

    shift_seq_ctrl #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .din       (din),
        .amt       (amt),
`ifdef SHIFT_SEQ_ROTATE_EN
        .rot       (rot),
`endif
        .busy      (busy),
        .step      (step),
        .done      (done),
        .dout      (dout),
        .state_dbg (state_dbg)
    );

    // Clock / cycle counter; cyc = k for the whole period following edge k.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard
    logic [WIDTH-1:0] exp_q[$];
    int               exp_cyc_q[$];
    int               exp_steps_q[$];
    int               tests = 0;
    int               fails = 0;
    int               step_cnt = 0;
    logic [WIDTH-1:0] exp_dout;
    int               exp_cyc;
    int               exp_steps;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h, required %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            step_cnt = 0;
        end else begin
            if (step) begin
                step_cnt++;
                check("step_implies_busy", 32'(busy), 32'd1);
            end
            if (done) begin
                check("done_busy", 32'(busy), 32'd1);
                check("done_no_step", 32'(step), 32'd0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: actual done with dout %b at cyc %0d, required no done", dout, cyc);
                end else begin
                    exp_dout  = exp_q.pop_front();
                    exp_cyc   = exp_cyc_q.pop_front();
                    exp_steps = exp_steps_q.pop_front();
                    check("dout", 32'(dout), 32'(exp_dout));
                    check("done_cycle", 32'(cyc), 32'(exp_cyc));
                    check("step_cycles", 32'(step_cnt), 32'(exp_steps));
                end
                step_cnt = 0;
            end
        end
    end

    // Driver: called at a falling edge; issues one request and waits until it has settled.
    task automatic run_op(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a, input logic r,
                          input logic [WIDTH-1:0] e, input int n);
        int t;
        t = cyc + 1 + n;
        exp_q.push_back(e);
        exp_cyc_q.push_back(t);
        exp_steps_q.push_back(n);
        din   = d;
        amt   = a;
`ifdef SHIFT_SEQ_ROTATE_EN
        rot   = r;
`else
        if (r) $display("rotate request ignored in zero-fill build");
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t + 2) @(negedge clk);
        check("dout_hold", 32'(dout), 32'(e));
    endtask

    int c;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        amt   = '0;
`ifdef SHIFT_SEQ_ROTATE_EN
        rot   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_step", 32'(step), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed zero-fill vectors: din, amt, rot, expected dout, expected step cycles
        run_op(4'b1011, 3'd1, 1'b0, 4'b0110, 1);
        run_op(4'b0011, 3'd3, 1'b0, 4'b1000, 3);
        run_op(4'b1010, 3'd0, 1'b0, 4'b1010, 0);
        run_op(4'b1111, 3'd7, 1'b0, 4'b0000, 4);
        run_op(4'b0110, 3'd2, 1'b0, 4'b1000, 2);
        run_op(4'b1101, 3'd4, 1'b0, 4'b0000, 4);
        run_op(4'b0111, 3'd5, 1'b0, 4'b0000, 4);

        // Start held high: two operations, one IDLE cycle between them
        c = cyc;
        exp_q.push_back(4'b0110); exp_cyc_q.push_back(c + 2); exp_steps_q.push_back(1);
        exp_q.push_back(4'b0110); exp_cyc_q.push_back(c + 5); exp_steps_q.push_back(1);
        din = 4'b1011; amt = 3'd1; start = 1'b1;
        while (cyc < c + 4) @(negedge clk);
        start = 1'b0;
        while (cyc < c + 7) @(negedge clk);
        check("held_start_dout", 32'(dout), 32'h6);

        // Starts during SHIFT and during DONE are ignored
        c = cyc;
        exp_q.push_back(4'b1000); exp_cyc_q.push_back(c + 4); exp_steps_q.push_back(3);
        din = 4'b0001; amt = 3'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; din = 4'b1111; amt = 3'd0;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 4) @(negedge clk);
        start = 1'b1; din = 4'b1111; amt = 3'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("ignored_start_hold", 32'(dout), 32'h8);
        check("ignored_start_idle", 32'(state_dbg), 32'd0);

        // Reset in cycle 2 of a 3-step operation discards it
        din = 4'b0001; amt = 3'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midop_rst_busy", 32'(busy), 32'd0);
        check("midop_rst_done", 32'(done), 32'd0);
        check("midop_rst_step", 32'(step), 32'd0);
        check("midop_rst_dout", 32'(dout), 32'd0);
        check("midop_rst_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // rst and start together: rst wins
        rst = 1'b1; start = 1'b1; din = 4'b1111; amt = 3'd1;
        @(negedge clk);
        check("rst_start_state", 32'(state_dbg), 32'd0);
        check("rst_start_busy", 32'(busy), 32'd0);
        rst = 1'b0; start = 1'b0;
        repeat (6) @(negedge clk);

        run_op(4'b0011, 3'd3, 1'b0, 4'b1000, 3);

`ifdef SHIFT_SEQ_ROTATE_EN
        run_op(4'b1001, 3'd1, 1'b1, 4'b0011, 1);
        run_op(4'b1001, 3'd5, 1'b1, 4'b0011, 1);
        run_op(4'b1001, 3'd4, 1'b1, 4'b1001, 0);
        run_op(4'b0110, 3'd3, 1'b1, 4'b0011, 3);
        run_op(4'b1001, 3'd1, 1'b0, 4'b0010, 1);
        run_op(4'b1001, 3'd6, 1'b0, 4'b0000, 4);
`endif

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
